// File: rtl/regfile_wr_arbiter_if.sv
// Write-offer bus between two requesters and the register-file write arbiter.
// The master side offers writes; the slave side returns ready and the write port.
interface regfile_wr_arbiter_if;
  logic        req0;
  logic        req1;
  logic [4:0]  addr0;
  logic [4:0]  addr1;
  logic [31:0] data0;
  logic [31:0] data1;
  logic        rdy0;
  logic        rdy1;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (
    output req0, req1, addr0, addr1, data0, data1,
    input  rdy0, rdy1, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req0, req1, addr0, addr1, data0, data1,
    output rdy0, rdy1, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter for a 32x32 register file, one skid buffer per requester.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 has fixed priority.
module regfile_wr_arbiter (
  input  logic                 clock,
  input  logic                 clr,
  regfile_wr_arbiter_if.slave  bus
);

  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic [1:0][4:0]  addr_q;
  logic [1:0][4:0]  addr_d;
  logic [1:0][31:0] data_q;
  logic [1:0][31:0] data_d;
  logic             wr_en_q;
  logic             wr_en_d;
  logic [4:0]       wr_addr_q;
  logic [4:0]       wr_addr_d;
  logic [31:0]      wr_data_q;
  logic [31:0]      wr_data_d;

  logic [1:0]       req_s;
  logic [1:0]       rdy_s;
  logic [1:0]       xfer_s;
  logic [1:0]       gnt_oh_s;
  logic [1:0][4:0]  addr_in_s;
  logic [1:0][31:0] data_in_s;
  logic             gnt_vld_s;
  logic             gnt_idx_s;
  logic             pick_s;
  logic [4:0]       gnt_addr_s;
  logic [31:0]      gnt_data_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q;
  logic ptr_d;

  // On contention the requester that did not win last time goes first
  assign pick_s = ~ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_s) begin
      ptr_d = gnt_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick_s = 1'b0;
`endif

  assign req_s     = {bus.req1, bus.req0};
  assign addr_in_s = {bus.addr1, bus.addr0};
  assign data_in_s = {bus.data1, bus.data0};

  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = 1'b0;
    case (full_q)
      2'b01: begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = 1'b0;
      end
      2'b10: begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = 1'b1;
      end
      2'b11: begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = pick_s;
      end
      default: begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = 1'b0;
      end
    endcase
  end

  // A granted buffer frees itself this cycle, so its requester may refill it at the same edge
  assign gnt_oh_s   = {gnt_vld_s & gnt_idx_s, gnt_vld_s & ~gnt_idx_s};
  assign rdy_s      = ~full_q | gnt_oh_s;
  assign xfer_s     = req_s & rdy_s;
  assign gnt_addr_s = addr_q[gnt_idx_s];
  assign gnt_data_s = data_q[gnt_idx_s];

  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    for (int i = 0; i < 2; i++) begin
      if (xfer_s[i]) begin
        full_d[i] = 1'b1;
        addr_d[i] = addr_in_s[i];
        data_d[i] = data_in_s[i];
      end else if (gnt_oh_s[i]) begin
        full_d[i] = 1'b0;
      end else begin
        full_d[i] = full_q[i];
      end
    end
  end

  // Register 0 is hardwired zero: its entries drain without a write strobe
  always_comb begin
    wr_en_d   = gnt_vld_s & (gnt_addr_s != 5'd0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (gnt_vld_s) begin
      wr_addr_d = gnt_addr_s;
      wr_data_d = gnt_data_s;
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      full_q    <= 2'b00;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      full_q    <= full_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.rdy0    = rdy_s[0];
  assign bus.rdy1    = rdy_s[1];
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clock in rising edge, clr asynchronous active-high reset.
REQ-002 The block SHALL have these ports: clock  in  1  rising-edge clock.
REQ-003 clr  in  1  asynchronous active-high reset.
REQ-004 req0 / req1  in  1  requester i offers a write this cycle.
REQ-005 addr0 / addr1  in  5  destination register of requester i.
REQ-006 data0 / data1  in  32  write data of requester i.
REQ-007 rdy0 / rdy1  out  1  requester i offer accepted at next rising edge if reqi=1.
REQ-008 wr_en  out  1  registered write enable to the 32x32 register file.
REQ-009 wr_addr  out  5  registered write address.
REQ-010 wr_data  out  32  registered write data.

Function
REQ-011 The block SHALL hold one buffer per requester: full bit, 5-bit address, 32-bit data.
REQ-012 Handshake: a transfer from requester i SHALL occur at a rising edge where reqi=1 and rdyi=1; the buffer loads addri/datai and sets full.
REQ-013 rdyi SHALL equal (not fulli) or granti, combinationally; reqi SHALL be ignored when rdyi=0.
REQ-014 Grant: with one buffer full, that buffer SHALL be granted; with both full, selection follows REQ-027/028; with none full, no grant.
REQ-015 At each rising edge the granted buffer SHALL drain: full clears unless the same requester transfers at that edge, in which case the buffer reloads and full stays 1.
REQ-016 At each rising edge wr_en SHALL load 1 if a grant exists and the granted address is nonzero, else 0; wr_addr/wr_data load the granted buffer contents on any grant and hold otherwise.
REQ-017 A granted entry with address 0 SHALL drain without asserting wr_en (r0 is hardwired zero).
REQ-018 Latency: an offer accepted at edge N with no contention SHALL appear on wr_en/wr_addr/wr_data after edge N+1.
REQ-019 Throughput: one write per cycle total; a single requester with continuous reqi SHALL sustain one accepted write per cycle.
REQ-020 No write SHALL be lost or duplicated; writes from one requester SHALL reach the output in acceptance order.
REQ-021 Identical addresses in both buffers SHALL be written in two separate cycles in grant order; no merging.

Reset
REQ-022 While clr=1, both full bits SHALL clear, and wr_en SHALL be 0 with wr_addr=0 and wr_data=0, asynchronously.
REQ-023 While clr=1, rdy0=rdy1=1 and no transfer or grant SHALL occur.
REQ-024 Reset mid-operation SHALL discard buffered writes and not emit them afterwards.
REQ-025 The round-robin pointer (last granted) SHALL reset to 1, so requester 0 wins the first contention.
REQ-026 First accepted transfer SHALL be possible at the first rising edge after clr deasserts.

Configuration
REQ-027 With macro ARB_ROUND_ROBIN_EN defined, on contention the requester not last granted SHALL win; the pointer updates on every grant to the granted index.
REQ-028 Without ARB_ROUND_ROBIN_EN, requester 0 SHALL always win on contention; no pointer register is built.

Verification
REQ-029 Reset: clr=1 for two cycles with both reqs high -> wr_en=0, wr_addr=0, wr_data=0, rdy0=rdy1=1; no write after release until new offers.
REQ-030 Single write: req0, addr0=5, data0=FFFFFFFF for one edge -> one cycle later wr_en=1, wr_addr=5, wr_data=FFFFFFFF, then wr_en=0.
REQ-031 Contention (ARB_ROUND_ROBIN_EN): req0 and req1 held 4 cycles, addr0=3/data0=A5A5A5A5, addr1=4/data1=5A5A5A5A -> outputs alternate reg3, reg4, reg3, reg4...; rdy of the loser 0 in its waiting cycle.
REQ-032 Contention without macro: same stimulus -> requester 0 streams every cycle, requester 1 written only after req0 drops.
REQ-033 r0 drop: req1, addr1=0, data1=12345678 -> buffer drains in one cycle, wr_en stays 0.
REQ-034 Reset mid-operation: both buffers full, assert clr one cycle -> wr_en drops immediately; no buffered write appears after release.
